// File: rtl/maj_tt_pkg.sv
// Shared types and constants for the MAJ-3 network truth-table extractor.
package maj_tt_pkg;

   localparam int NIN = 7;

   localparam logic [3:0] SEL_CONST0 = 4'd0;
   localparam logic [3:0] SEL_X0     = 4'd1;
   localparam logic [3:0] SEL_W0     = 4'd8;

   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;

   typedef struct packed {
      logic [2:0] inv;
      logic [3:0] sel_c;
      logic [3:0] sel_b;
      logic [3:0] sel_a;
   } gate_cfg_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/maj3_node.sv
// One MAJ-3 evaluator: three operand muxes, optional edge complement, majority.
// MAJ_COMPL_EDGE_EN enables the per-operand inversion bits.
module maj3_node
   import maj_tt_pkg::*;
#(
   parameter int NGATES = 6
) (
   input  gate_cfg_t         cfg,
   input  logic [NIN-1:0]    x,
   input  logic [NGATES-1:0] w,
   output logic              value
);

   // Unmatched selects (const0 and codes past the last gate) read 0.
   function automatic logic pick(input logic [3:0] sel, input logic [NIN-1:0] xv,
                                 input logic [NGATES-1:0] wv);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NIN; i++)
         if (int'(sel) == int'(SEL_X0) + i) r = xv[i];
      for (int j = 0; j < NGATES; j++)
         if (int'(sel) == int'(SEL_W0) + j) r = wv[j];
      return r;
   endfunction

   logic [2:0] ops;

   always_comb begin
      ops[0] = pick(cfg.sel_a, x, w);
      ops[1] = pick(cfg.sel_b, x, w);
      ops[2] = pick(cfg.sel_c, x, w);
`ifdef MAJ_COMPL_EDGE_EN
      ops    = ops ^ cfg.inv;
`endif
      value  = maj3(ops[0], ops[1], ops[2]);
   end

`ifndef MAJ_COMPL_EDGE_EN
   logic unused_inv;
   assign unused_inv = ^cfg.inv;
`endif

endmodule

// File: rtl/maj_tt_extractor.sv
// Sweeps a programmed MAJ-3 network over all 128 minterms, one gate per cycle.
// MAJ_COMPL_EDGE_EN enables complemented operand edges.
module maj_tt_extractor
   import maj_tt_pkg::*;
#(
   parameter int NGATES = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cfg_we,
   input  logic [3:0]   cfg_addr,
   input  logic [14:0]  cfg_data,
   input  logic [3:0]   out_sel,
   input  logic         start,
   output logic         busy,
   output logic         tt_valid,
   input  logic         tt_ready,
   output logic [127:0] tt_data
);

   gate_cfg_t         gates_q [NGATES];
   state_t            state_q;
   logic              busy_q, valid_q;
   logic [127:0]      tt_q;
   logic [NIN-1:0]    m_q;
   logic [3:0]        g_q, osel_q;
   logic [NGATES-1:0] w_q;

   gate_cfg_t         cur_cfg;
   logic [NGATES-1:0] w_vis, w_next;
   logic              gate_val, out_bit, last_gate, last_min;

   // Gates at or after the current index are hidden so forward references read 0.
   always_comb begin
      cur_cfg = '0;
      for (int k = 0; k < NGATES; k++)
         if (int'(g_q) == k) cur_cfg = gates_q[k];
      for (int j = 0; j < NGATES; j++)
         w_vis[j] = w_q[j] & (j < int'(g_q));
   end

   maj3_node #(.NGATES(NGATES)) u_node (
      .cfg   (cur_cfg),
      .x     (m_q),
      .w     (w_vis),
      .value (gate_val)
   );

   // The output bit must include the result computed in this same cycle.
   always_comb begin
      w_next = w_q;
      for (int k = 0; k < NGATES; k++)
         if (int'(g_q) == k) w_next[k] = gate_val;
      out_bit = 1'b0;
      for (int k = 0; k < NGATES; k++)
         if (int'(osel_q) == k) out_bit = w_next[k];
      last_gate = (int'(g_q) == NGATES - 1);
      last_min  = (m_q == '1);
   end

   // NOTE: the gate array is small and must read as const0 right after reset,
   // so it lives in resettable flops rather than an unreset RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NGATES; k++) gates_q[k] <= '0;
      end else if (cfg_we && state_q == IDLE) begin
         for (int k = 0; k < NGATES; k++) begin
            if (int'(cfg_addr) == k) begin
`ifdef MAJ_COMPL_EDGE_EN
               gates_q[k] <= gate_cfg_t'(cfg_data);
`else
               gates_q[k]     <= gate_cfg_t'({3'b000, cfg_data[11:0]});
`endif
            end
         end
      end
   end

`ifndef MAJ_COMPL_EDGE_EN
   logic unused_inv;
   assign unused_inv = ^cfg_data[14:12];
`endif

   // NOTE: all state is updated with non-blocking assignments so every branch
   // sees the pre-edge values of m_q/g_q/w_q.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         tt_q    <= '0;
         m_q     <= '0;
         g_q     <= '0;
         osel_q  <= '0;
         w_q     <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= EVAL;
                  busy_q  <= 1'b1;
                  osel_q  <= out_sel;
                  w_q     <= '0;
                  m_q     <= '0;
                  g_q     <= '0;
               end
            end
            EVAL: begin
               w_q <= w_next;
               if (last_gate) begin
                  tt_q[m_q] <= out_bit;
                  g_q       <= '0;
                  if (last_min) state_q <= DONE;
                  else          m_q     <= m_q + 7'd1;
               end else begin
                  g_q <= g_q + 4'd1;
               end
            end
            DONE: begin
               if (valid_q && tt_ready) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
               end else begin
                  valid_q <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy     = busy_q;
   assign tt_valid = valid_q;
   assign tt_data  = tt_q;

endmodule
